// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative radix-2 restoring divider, one quotient bit per clock,
// with valid/ready handshakes on the operand and result sides.
module seq_restoring_divider #(
  parameter int WIDTH = 9
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [2*WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]     R,
  output logic                 DIV_BY_ZERO
);
  localparam int CW = $clog2(2*WIDTH+1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             r_state;
  logic [WIDTH:0]     r_rem;
  logic [2*WIDTH-1:0] r_quo;
  logic [WIDTH-1:0]   r_div;
  logic [CW-1:0]      r_cnt;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [2*WIDTH-1:0] r_q;
  logic [WIDTH-1:0]   r_r;
  logic               r_dbz;
  logic [WIDTH+1:0]   w_sh;
  logic [WIDTH+1:0]   w_trial;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nx;
  logic [2*WIDTH-1:0] w_quo_nx;
  // One extra bit on the trial keeps the sign of rem - divisor exact.
  always_comb begin
    w_sh     = {r_rem, r_quo[2*WIDTH-1]};
    w_trial  = w_sh - (WIDTH+2)'(r_div);
    w_ge     = !w_trial[WIDTH+1];
    w_rem_nx = w_ge ? w_trial[WIDTH:0] : w_sh[WIDTH:0];
    w_quo_nx = {r_quo[2*WIDTH-2:0], w_ge};
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_q         <= '0;
      r_r         <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (IN_VALID && r_in_ready) begin
          r_in_ready <= 1'b0;
          if (B == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_q         <= '1;
            r_r         <= '0;
            r_dbz       <= 1'b1;
          end else begin
            r_state <= CALC;
            r_quo   <= A;
            r_div   <= B;
            r_rem   <= '0;
            r_cnt   <= CW'(2*WIDTH);
          end
        end
        CALC: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_q         <= w_quo_nx;
            r_r         <= w_rem_nx[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
        end
        DONE: if (OUT_READY) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign IN_READY    = r_in_ready;
  assign OUT_VALID   = r_out_valid;
  assign Q           = r_q;
  assign R           = r_r;
  assign DIV_BY_ZERO = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench; expected results come from plain / and % arithmetic.
module tb_seq_restoring_divider;
  localparam int W = 9;
  logic            CLK = 0;
  logic            RST = 1;
  logic            IN_VALID = 0;
  logic            IN_READY;
  logic [2*W-1:0]  A = '0;
  logic [W-1:0]    B = '0;
  logic            OUT_VALID;
  logic            OUT_READY;
  logic [2*W-1:0]  Q;
  logic [W-1:0]    R;
  logic            DIV_BY_ZERO;
  logic            rnd_rdy = 0;
  logic            rdy_val = 1;
  logic            r_rand = 0;
  int              n_cmp = 0;
  int              n_fail = 0;

  typedef struct {
    logic [2*W-1:0] q;
    logic [W-1:0]   r;
    logic           dbz;
  } exp_t;
  exp_t sb[$];

  seq_restoring_divider #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q(Q), .R(R), .DIV_BY_ZERO(DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    r_rand = 1'($urandom_range(0, 1));
  end
  always_comb OUT_READY = rnd_rdy ? r_rand : rdy_val;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every result handshake pops one expected entry.
  always @(negedge CLK) begin
    if (!RST) begin
      n_cmp++;
      if (OUT_VALID && IN_READY) begin
        n_fail++;
        $display("FAIL invariant: OUT_VALID and IN_READY both 1 at %0t", $time);
      end
      if (OUT_VALID && OUT_READY) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_result: got Q=%0d R=%0d, expected no output at %0t", Q, R, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (Q !== e.q || R !== e.r || DIV_BY_ZERO !== e.dbz) begin
            n_fail++;
            $display("FAIL result: got Q=%0d R=%0d DBZ=%0b, expected Q=%0d R=%0d DBZ=%0b at %0t",
                     Q, R, DIV_BY_ZERO, e.q, e.r, e.dbz, $time);
          end
        end
      end
    end
  end

  function automatic exp_t model(input logic [2*W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.dbz = (b == 0);
    e.q   = e.dbz ? {2*W{1'b1}} : a / b;
    e.r   = e.dbz ? '0 : W'(a % b);
    return e;
  endfunction

  // Presents operands until accepted; returns #1 after the accepting edge.
  task automatic op(input logic [2*W-1:0] a, input logic [W-1:0] b, input exp_t e);
    bit ok;
    ok = 0;
    IN_VALID = 1; A = a; B = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (IN_READY) begin
        sb.push_back(e);
        ok = 1;
      end
      @(posedge CLK); #1;
    end
    IN_VALID = 0;
    A = 18'($urandom); B = 9'($urandom);
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: got no accept, expected accept for A=%0d B=%0d", a, b);
    end
  endtask

  function automatic exp_t mk(input logic [2*W-1:0] q, input logic [W-1:0] r, input logic d);
    exp_t e;
    e.q = q; e.r = r; e.dbz = d;
    return e;
  endfunction

  task automatic wait_out(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge CLK);
      seen = OUT_VALID;
    end
    check(name, 32'(seen), 1);
  endtask

  initial begin
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
    logic [W-1:0]   x;
    repeat (3) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    check("rst_in_ready", 32'(IN_READY), 1);
    check("rst_out_valid", 32'(OUT_VALID), 0);
    check("rst_q", 32'(Q), 0);
    check("rst_r", 32'(R), 0);
    check("rst_dbz", 32'(DIV_BY_ZERO), 0);
    @(posedge CLK); #1;

    // Basic with exact latency: valid after 18th edge, not 17th
    op(1000, 7, mk(142, 6, 0));
    for (int i = 1; i <= 18; i++) begin
      @(posedge CLK); #1;
      if (i == 17) check("lat_edge17_valid", 32'(OUT_VALID), 0);
      if (i == 18) check("lat_edge18_valid", 32'(OUT_VALID), 1);
    end

    op(262143, 511, mk(513, 0, 0));
    op(5, 9, mk(0, 5, 0));
    op(262143, 1, mk(262143, 0, 0));

    // Divide by zero, result after a single edge
    op(1234, 0, mk(262143, 0, 1));
    check("dbz_lat_valid", 32'(OUT_VALID), 1);
    check("dbz_lat_flag", 32'(DIV_BY_ZERO), 1);
    op(10, 3, mk(3, 1, 0));
    wait_out("after_dbz_valid");

    // Backpressure: result held, new operands refused
    @(posedge CLK); #1;
    rdy_val = 0;
    op(1000, 7, mk(142, 6, 0));
    wait_out("bp_valid");
    IN_VALID = 1; A = 10; B = 3;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_hold_valid", 32'(OUT_VALID), 1);
      check("bp_no_ready", 32'(IN_READY), 0);
      check("bp_hold_q", 32'(Q), 142);
      check("bp_hold_r", 32'(R), 6);
    end
    @(posedge CLK); #1;
    rdy_val = 1;
    @(posedge CLK); #1;
    check("bp_release_valid", 32'(OUT_VALID), 0);
    check("bp_release_ready", 32'(IN_READY), 1);
    sb.push_back(mk(3, 1, 0));
    @(posedge CLK); #1;
    IN_VALID = 0;
    check("bp_new_accepted", 32'(IN_READY), 0);
    wait_out("bp_new_valid");

    // Reset at the 8th CALC edge discards the operation
    @(posedge CLK); #1;
    op(500, 7, mk(71, 3, 0));
    repeat (7) @(posedge CLK);
    #1 RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    sb.delete();
    @(negedge CLK);
    check("midrst_in_ready", 32'(IN_READY), 1);
    check("midrst_out_valid", 32'(OUT_VALID), 0);
    check("midrst_q", 32'(Q), 0);
    check("midrst_r", 32'(R), 0);
    repeat (25) @(posedge CLK);
    #1;
    op(100, 10, mk(10, 0, 0));

    // Round trip x*y / y with random consumer backpressure
    rnd_rdy = 1;
    op(18'(511 * 511), 511, mk(511, 0, 0));
    op(0, 1, mk(0, 0, 0));
    for (int i = 0; i < 250; i++) begin
      x = 9'($urandom_range(0, 511));
      b = 9'($urandom_range(1, 511));
      op(18'(x * b), b, mk(18'(x), 0, 0));
    end
    // General random operands, occasional zero divisor
    for (int i = 0; i < 250; i++) begin
      a = 18'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
      op(a, b, model(a, b));
    end
    rnd_rdy = 0;
    rdy_val = 1;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge CLK);
    @(negedge CLK); @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
